mem_tg_axi_txn_mon: RTL and testbench

//  Per-channel AXI-MM transaction throttle/monitor between a TG2 traffic generator (upstream) and the EMIF

---
 rtl/mem_tg_axi_txn_mon_pkg.sv | 34 +++
 rtl/mem_tg_axi_txn_mon_if.sv | 31 +++
 rtl/mem_tg_outst_ctr.sv | 44 ++++
 rtl/mem_tg_axi_txn_mon.sv | 113 +++++++++++
 tb/tb_mem_tg_axi_txn_mon.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_tg_axi_txn_mon_pkg.sv
// Shared constants, statistics record and saturating-increment helpers for the
// mem TG transaction monitor. The stats record is packed for the mem TG CSR block.
package mem_tg_mon_pkg;

  localparam int MON_BURST_W = 32;
  localparam int MON_BUSY_W  = 64;

  typedef struct packed {
    logic [MON_BURST_W-1:0] wr_bursts;
    logic [MON_BURST_W-1:0] rd_bursts;
    logic [MON_BUSY_W-1:0]  busy_cycles;
    logic                   tmo_err;
    logic                   cnt_err;
  } mem_tg_mon_stats_t;

  // Burst counters hold at all-ones instead of wrapping.
  function automatic logic [MON_BURST_W-1:0] sat_inc_burst(input logic [MON_BURST_W-1:0] v);
    if (v == {MON_BURST_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(MON_BURST_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Busy-cycle counter holds at all-ones instead of wrapping.
  function automatic logic [MON_BUSY_W-1:0] sat_inc_busy(input logic [MON_BUSY_W-1:0] v);
    if (v == {MON_BUSY_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(MON_BUSY_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/mem_tg_axi_txn_mon_if.sv
// AXI-MM address/response handshake bundle seen by the transaction monitor.
// slave: the monitor's view. master: the surrounding TG / EMIF side.
interface mem_tg_axi_txn_mon_if;

  logic s_awvalid;
  logic s_awready;
  logic m_awvalid;
  logic m_awready;
  logic s_arvalid;
  logic s_arready;
  logic m_arvalid;
  logic m_arready;
  logic bvalid;
  logic bready;
  logic rvalid;
  logic rready;
  logic rlast;

  modport slave (
    input  s_awvalid, m_awready, s_arvalid, m_arready,
    input  bvalid, bready, rvalid, rready, rlast,
    output s_awready, m_awvalid, s_arready, m_arvalid
  );

  modport master (
    output s_awvalid, m_awready, s_arvalid, m_arready,
    output bvalid, bready, rvalid, rready, rlast,
    input  s_awready, m_awvalid, s_arready, m_arvalid
  );

endinterface

// File: rtl/mem_tg_outst_ctr.sv
// Outstanding-transaction counter: +1 on request accept, -1 on completion.
// 'ok' comes from the registered count only, so a completion frees its slot
// one cycle later. A lone completion at zero flags underflow and keeps zero.
module mem_tg_outst_ctr #(
  parameter  int MAX = 16,
  localparam int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         ok,
  output logic         underflow
);

  localparam logic [W-1:0] MAX_C  = W'(MAX);
  localparam logic [W-1:0] ZERO_C = {W{1'b0}};
  localparam logic [W-1:0] ONE_C  = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_r;

  // Admission and underflow decode from the registered count.
  always_comb begin
    ok        = (count_r < MAX_C);
    underflow = dec & ~inc & (count_r == ZERO_C);
  end

  // Track outstanding count; simultaneous inc/dec cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= ZERO_C;
    end else if (inc & ~dec) begin
      count_r <= count_r + ONE_C;
    end else if (dec & ~inc & (count_r != ZERO_C)) begin
      count_r <= count_r - ONE_C;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/mem_tg_axi_txn_mon.sv
// Per-channel AXI-MM throttle/monitor between the TG and the EMIF bridge.
// Caps outstanding AW/AR, counts bursts and busy cycles, runs a response watchdog.
module mem_tg_axi_txn_mon
  import mem_tg_mon_pkg::*;
#(
  parameter  int MAX_WR_OUTST = 16,
  parameter  int MAX_RD_OUTST = 16,
  parameter  int TMO_W        = 32,
  localparam int OW_W         = $clog2(MAX_WR_OUTST + 1),
  localparam int OR_W         = $clog2(MAX_RD_OUTST + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_tg_axi_txn_mon_if.slave    bus,
  input  logic [TMO_W-1:0]       cfg_timeout,
  input  logic                   clr,
  output logic [OW_W-1:0]        wr_outst,
  output logic [OR_W-1:0]        rd_outst,
  output logic [MON_BURST_W-1:0] wr_bursts,
  output logic [MON_BURST_W-1:0] rd_bursts,
  output logic [MON_BUSY_W-1:0]  busy_cycles,
  output logic                   tmo_err,
  output logic                   cnt_err
);

  localparam logic [TMO_W-1:0] TMO_ZERO_C = {TMO_W{1'b0}};
  localparam logic [TMO_W-1:0] TMO_ONE_C  = {{(TMO_W-1){1'b0}}, 1'b1};

  logic              wr_ok_s, rd_ok_s, wr_uf_s, rd_uf_s;
  logic              aw_hs_s, ar_hs_s, b_hs_s, r_last_hs_s, progress_s;
  logic              busy_s, tmo_fire_s;
  logic [OW_W-1:0]   wr_cnt_s;
  logic [OR_W-1:0]   rd_cnt_s;
  logic [TMO_W-1:0]  wd_cnt_r;
  mem_tg_mon_stats_t stats_r;

  // Zero-latency gating; held closed while in reset.
  always_comb begin
    bus.m_awvalid = ~rst & bus.s_awvalid & wr_ok_s;
    bus.s_awready = ~rst & bus.m_awready & wr_ok_s;
    bus.m_arvalid = ~rst & bus.s_arvalid & rd_ok_s;
    bus.s_arready = ~rst & bus.m_arready & rd_ok_s;
  end

  // Handshake, busy and watchdog-fire decode.
  always_comb begin
    aw_hs_s     = ~rst & bus.s_awvalid & wr_ok_s & bus.m_awready;
    ar_hs_s     = ~rst & bus.s_arvalid & rd_ok_s & bus.m_arready;
    b_hs_s      = bus.bvalid & bus.bready;
    r_last_hs_s = bus.rvalid & bus.rready & bus.rlast;
    progress_s  = b_hs_s | (bus.rvalid & bus.rready);
    busy_s      = (wr_cnt_s != {OW_W{1'b0}}) | (rd_cnt_s != {OR_W{1'b0}});
    tmo_fire_s  = (cfg_timeout != TMO_ZERO_C) & busy_s & ~progress_s &
                  (wd_cnt_r == (cfg_timeout - TMO_ONE_C));
  end

  mem_tg_outst_ctr #(.MAX(MAX_WR_OUTST)) u_wr_ctr (
    .clk       (clk),
    .rst       (rst),
    .inc       (aw_hs_s),
    .dec       (b_hs_s),
    .count     (wr_cnt_s),
    .ok        (wr_ok_s),
    .underflow (wr_uf_s)
  );

  mem_tg_outst_ctr #(.MAX(MAX_RD_OUTST)) u_rd_ctr (
    .clk       (clk),
    .rst       (rst),
    .inc       (ar_hs_s),
    .dec       (r_last_hs_s),
    .count     (rd_cnt_s),
    .ok        (rd_ok_s),
    .underflow (rd_uf_s)
  );

  // Watchdog: counts consecutive busy cycles without any B or R beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_r <= TMO_ZERO_C;
    end else if (clr | ~busy_s | progress_s) begin
      wd_cnt_r <= TMO_ZERO_C;
    end else if (wd_cnt_r != {TMO_W{1'b1}}) begin
      wd_cnt_r <= wd_cnt_r + TMO_ONE_C;
    end else begin
      wd_cnt_r <= wd_cnt_r;
    end
  end

  // Statistics and sticky flags; clr wins over same-cycle updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stats_r <= '0;
    end else if (clr) begin
      stats_r <= '0;
    end else begin
      stats_r.wr_bursts   <= aw_hs_s ? sat_inc_burst(stats_r.wr_bursts) : stats_r.wr_bursts;
      stats_r.rd_bursts   <= ar_hs_s ? sat_inc_burst(stats_r.rd_bursts) : stats_r.rd_bursts;
      stats_r.busy_cycles <= busy_s ? sat_inc_busy(stats_r.busy_cycles) : stats_r.busy_cycles;
      stats_r.tmo_err     <= stats_r.tmo_err | tmo_fire_s;
      stats_r.cnt_err     <= stats_r.cnt_err | wr_uf_s | rd_uf_s;
    end
  end

  assign wr_outst    = wr_cnt_s;
  assign rd_outst    = rd_cnt_s;
  assign wr_bursts   = stats_r.wr_bursts;
  assign rd_bursts   = stats_r.rd_bursts;
  assign busy_cycles = stats_r.busy_cycles;
  assign tmo_err     = stats_r.tmo_err;
  assign cnt_err     = stats_r.cnt_err;

endmodule

// File: tb/tb_mem_tg_axi_txn_mon.sv
// Self-checking bench for mem_tg_axi_txn_mon: directed scenarios followed by
// randomized traffic, all checked against a transaction-level reference model.
module tb_mem_tg_axi_txn_mon;

  localparam int MAX_WR = 4;
  localparam int MAX_RD = 3;

  logic        clk;
  logic        rst;
  logic [31:0] cfg_timeout;
  logic        clr;
  logic [2:0]  wr_outst;
  logic [1:0]  rd_outst;
  logic [31:0] wr_bursts;
  logic [31:0] rd_bursts;
  logic [63:0] busy_cycles;
  logic        tmo_err;
  logic        cnt_err;

  mem_tg_axi_txn_mon_if bus ();

  mem_tg_axi_txn_mon #(
    .MAX_WR_OUTST (MAX_WR),
    .MAX_RD_OUTST (MAX_RD),
    .TMO_W        (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .cfg_timeout (cfg_timeout),
    .clr         (clr),
    .wr_outst    (wr_outst),
    .rd_outst    (rd_outst),
    .wr_bursts   (wr_bursts),
    .rd_bursts   (rd_bursts),
    .busy_cycles (busy_cycles),
    .tmo_err     (tmo_err),
    .cnt_err     (cnt_err)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state: transaction-level view of the monitor.
  int          m_wr, m_rd, m_idle;
  logic [31:0] m_wrb, m_rdb;
  logic [63:0] m_busy;
  bit          m_tmo, m_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_idle = 0;
    m_wrb = 32'd0; m_rdb = 32'd0; m_busy = 64'd0;
    m_tmo = 1'b0; m_cnt = 1'b0;
  endtask

  task automatic check_gate();
    bit wok, rok;
    wok = (m_wr < MAX_WR);
    rok = (m_rd < MAX_RD);
    chk("m_awvalid", bus.m_awvalid, bus.s_awvalid & wok);
    chk("s_awready", bus.s_awready, bus.m_awready & wok);
    chk("m_arvalid", bus.m_arvalid, bus.s_arvalid & rok);
    chk("s_arready", bus.s_arready, bus.m_arready & rok);
  endtask

  task automatic check_regs();
    chk("wr_outst", wr_outst, m_wr);
    chk("rd_outst", rd_outst, m_rd);
    chk("wr_bursts", wr_bursts, m_wrb);
    chk("rd_bursts", rd_bursts, m_rdb);
    chk("busy_cycles", busy_cycles, m_busy);
    chk("tmo_err", tmo_err, m_tmo);
    chk("cnt_err", cnt_err, m_cnt);
  endtask

  // Apply the effect of one clock edge given the inputs currently driven.
  task automatic model_edge();
    bit aw, ar, b, rl, rb, busy, uf;
    aw   = bus.s_awvalid && bus.m_awready && (m_wr < MAX_WR);
    ar   = bus.s_arvalid && bus.m_arready && (m_rd < MAX_RD);
    b    = bus.bvalid && bus.bready;
    rb   = bus.rvalid && bus.rready;
    rl   = rb && bus.rlast;
    busy = (m_wr != 0) || (m_rd != 0);
    uf   = 1'b0;
    if (aw && !b) m_wr = m_wr + 1;
    else if (b && !aw) begin
      if (m_wr == 0) uf = 1'b1; else m_wr = m_wr - 1;
    end
    if (ar && !rl) m_rd = m_rd + 1;
    else if (rl && !ar) begin
      if (m_rd == 0) uf = 1'b1; else m_rd = m_rd - 1;
    end
    if (clr) begin
      m_wrb = 32'd0; m_rdb = 32'd0; m_busy = 64'd0;
      m_tmo = 1'b0; m_cnt = 1'b0; m_idle = 0;
    end else begin
      if (aw && m_wrb != 32'hFFFF_FFFF) m_wrb = m_wrb + 32'd1;
      if (ar && m_rdb != 32'hFFFF_FFFF) m_rdb = m_rdb + 32'd1;
      if (busy) m_busy = m_busy + 64'd1;
      if (uf) m_cnt = 1'b1;
      if (!busy || b || rb) m_idle = 0;
      else begin
        m_idle = m_idle + 1;
        if (cfg_timeout != 32'd0 && m_idle == int'(cfg_timeout)) m_tmo = 1'b1;
      end
    end
  endtask

  task automatic step(input bit saw, input bit maw, input bit sar, input bit mar,
                      input bit bv, input bit br, input bit rv, input bit rr,
                      input bit rl, input bit c);
    bus.s_awvalid = saw; bus.m_awready = maw;
    bus.s_arvalid = sar; bus.m_arready = mar;
    bus.bvalid = bv; bus.bready = br;
    bus.rvalid = rv; bus.rready = rr; bus.rlast = rl;
    clr = c;
    #1;
    check_gate();
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0,0,0,0,0,0,0,0,0,0);
  endtask

  task automatic b_resp();
    step(0,0,0,0,1,1,0,0,0,0);
  endtask

  // Mid-cycle asynchronous reset with all valids/readies asserted.
  task automatic do_reset();
    bus.s_awvalid = 1'b1; bus.m_awready = 1'b1;
    bus.s_arvalid = 1'b1; bus.m_arready = 1'b1;
    bus.bvalid = 1'b0; bus.bready = 1'b0;
    bus.rvalid = 1'b0; bus.rready = 1'b0; bus.rlast = 1'b0;
    clr = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_m_awvalid", bus.m_awvalid, 1'b0);
    chk("rst_s_awready", bus.s_awready, 1'b0);
    chk("rst_m_arvalid", bus.m_arvalid, 1'b0);
    chk("rst_s_arready", bus.s_arready, 1'b0);
    check_regs();
    @(posedge clk);
    #1;
    chk("rst_hold_m_awvalid", bus.m_awvalid, 1'b0);
    chk("rst_hold_s_arready", bus.s_arready, 1'b0);
    check_regs();
    rst = 1'b0;
    bus.s_awvalid = 1'b0; bus.m_awready = 1'b0;
    bus.s_arvalid = 1'b0; bus.m_arready = 1'b0;
  endtask

  initial begin
    int resp_pct;
    logic [63:0] busy0;
    clk = 1'b0;
    rst = 1'b1;
    clr = 1'b0;
    cfg_timeout = 32'd0;
    bus.s_awvalid = 1'b1; bus.m_awready = 1'b1;
    bus.s_arvalid = 1'b1; bus.m_arready = 1'b1;
    bus.bvalid = 1'b0; bus.bready = 1'b0;
    bus.rvalid = 1'b0; bus.rready = 1'b0; bus.rlast = 1'b0;
    model_reset();
    #12;
    chk("init_m_awvalid", bus.m_awvalid, 1'b0);
    chk("init_s_awready", bus.s_awready, 1'b0);
    chk("init_m_arvalid", bus.m_arvalid, 1'b0);
    chk("init_s_arready", bus.s_arready, 1'b0);
    check_regs();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Back-to-back AW into a 4-deep cap, then one B re-opens a slot.
    for (int k = 0; k < 6; k++) step(1,1,0,0,0,0,0,0,0,0);
    chk("t1_wr_outst", wr_outst, 3'd4);
    chk("t1_wr_bursts", wr_bursts, 32'd4);
    step(1,1,0,0,1,1,0,0,0,0);
    chk("t1_after_b", wr_outst, 3'd3);
    step(1,1,0,0,0,0,0,0,0,0);
    chk("t1_fifth_aw", wr_bursts, 32'd5);

    // Same-cycle AW and B at two outstanding.
    b_resp(); b_resp();
    step(1,1,0,0,1,1,0,0,0,0);
    chk("t2_outst", wr_outst, 3'd2);
    chk("t2_bursts", wr_bursts, 32'd6);

    // Drain, underflow, then clear.
    b_resp(); b_resp(); b_resp();
    chk("t5_outst0", wr_outst, 3'd0);
    chk("t5_cnt_err", cnt_err, 1'b1);
    step(0,0,0,0,0,0,0,0,0,1);
    chk("t5_clr_cnt_err", cnt_err, 1'b0);
    chk("t5_clr_bursts", wr_bursts, 32'd0);

    // Watchdog fires after exactly cfg_timeout idle busy cycles.
    cfg_timeout = 32'd100;
    step(1,1,0,0,0,0,0,0,0,0);
    idle(99);
    chk("t4_tmo_99", tmo_err, 1'b0);
    idle(1);
    chk("t4_tmo_100", tmo_err, 1'b1);
    b_resp();
    cfg_timeout = 32'd0;
    step(0,0,0,0,0,0,0,0,0,1);
    step(1,1,0,0,0,0,0,0,0,0);
    idle(150);
    chk("t4_tmo_disabled", tmo_err, 1'b0);
    b_resp();

    // One read burst of four beats with a gap before the data.
    step(0,0,0,0,0,0,0,0,0,1);
    busy0 = busy_cycles;
    step(0,0,1,1,0,0,0,0,0,0);
    idle(1);
    for (int k = 0; k < 3; k++) step(0,0,0,0,0,0,1,1,0,0);
    chk("t3_rd_mid", rd_outst, 2'd1);
    step(0,0,0,0,0,0,1,1,1,0);
    chk("t3_rd_done", rd_outst, 2'd0);
    chk("t3_busy", busy_cycles - busy0, 64'd5);

    // Reset while three reads are outstanding.
    for (int k = 0; k < 3; k++) step(0,0,1,1,0,0,0,0,0,0);
    chk("t6_rd3", rd_outst, 2'd3);
    do_reset();

    // Randomized traffic with varying response pressure and timeouts.
    resp_pct = 30;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin
        case ($urandom_range(2, 0))
          0: resp_pct = 2;
          1: resp_pct = 30;
          default: resp_pct = 70;
        endcase
        cfg_timeout = $urandom_range(25, 0);
      end
      if (i == 1200 || i == 2400) do_reset();
      step($urandom_range(99, 0) < 60, $urandom_range(99, 0) < 70,
           $urandom_range(99, 0) < 60, $urandom_range(99, 0) < 70,
           $urandom_range(99, 0) < resp_pct, $urandom_range(99, 0) < 80,
           $urandom_range(99, 0) < resp_pct, $urandom_range(99, 0) < 80,
           $urandom_range(2, 0) == 0, $urandom_range(99, 0) < 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
